// File: rtl/reservation_station_pkg.sv
// Shared widths, payload structs and the CDB snoop helper for the reservation station.
package reservation_station_pkg;

  localparam int unsigned IDWidth         = 32;
  localparam int unsigned ROBWidth        = 4;
  localparam int unsigned InstTypeWidth   = 6;
  localparam int unsigned AddressWidth    = 32;
  localparam int unsigned RS_SIZE_DEFAULT = 16;

  typedef struct packed {
    logic [ROBWidth-1:0] q;
    logic [IDWidth-1:0]  v;
  } operand_t;

  typedef struct packed {
    logic                en;
    logic [ROBWidth-1:0] tag;
    logic [IDWidth-1:0]  value;
  } cdb_t;

  typedef struct packed {
    logic                     busy;
    logic [InstTypeWidth-1:0] opcode;
    operand_t                 j;
    operand_t                 k;
    logic [IDWidth-1:0]       a;
    logic [AddressWidth-1:0]  pc;
    logic [ROBWidth-1:0]      dest;
  } rs_entry_t;

  typedef struct packed {
    logic [InstTypeWidth-1:0] opcode;
    logic [IDWidth-1:0]       vj;
    logic [IDWidth-1:0]       vk;
    logic [IDWidth-1:0]       a;
    logic [AddressWidth-1:0]  pc;
    logic [ROBWidth-1:0]      dest;
  } issue_t;

  // Resolve a waiting operand against both buses; tag 0 never matches, ALU bus wins a tie.
  function automatic operand_t snoop(input operand_t op, input cdb_t alu, input cdb_t lsb);
    operand_t res;
    res = op;
    if (op.q != '0) begin
      if (alu.en && (alu.tag == op.q)) begin
        res.q = '0;
        res.v = alu.value;
      end else if (lsb.en && (lsb.tag == op.q)) begin
        res.q = '0;
        res.v = lsb.value;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: reports whether any request bit is set and the first one.
module rs_select #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0]         req,
  output logic                 found_c,
  output logic [$clog2(N)-1:0] idx_c
);

  localparam int unsigned IdxWidth = $clog2(N);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_c = 1'b1;
        idx_c   = IdxWidth'(i);
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU/branch reservation station: buffers dispatched ops, snoops the CDB, issues one ready op per cycle.
// Define RS_DUAL_CDB_EN to add the load/store CDB as a second wakeup source.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEFAULT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_rs_clear_in,
  input  logic                     dispatcher_rs_en_in,
  input  logic [IDWidth-1:0]       dispatcher_rs_a_in,
  input  logic [ROBWidth-1:0]      dispatcher_rs_qj_in,
  input  logic [ROBWidth-1:0]      dispatcher_rs_qk_in,
  input  logic [IDWidth-1:0]       dispatcher_rs_vj_in,
  input  logic [IDWidth-1:0]       dispatcher_rs_vk_in,
  input  logic [ROBWidth-1:0]      dispatcher_rs_dest_in,
  input  logic [AddressWidth-1:0]  dispatcher_rs_pc_in,
  input  logic [InstTypeWidth-1:0] dispatcher_rs_opcode_in,
  input  logic                     cdb_alu_en_in,
  input  logic [ROBWidth-1:0]      cdb_alu_tag_in,
  input  logic [IDWidth-1:0]       cdb_alu_value_in,
`ifdef RS_DUAL_CDB_EN
  input  logic                     cdb_lsb_en_in,
  input  logic [ROBWidth-1:0]      cdb_lsb_tag_in,
  input  logic [IDWidth-1:0]       cdb_lsb_value_in,
`endif
  output logic                     rs_full_out,
  output logic                     rs_alu_en_out,
  output logic [InstTypeWidth-1:0] rs_alu_opcode_out,
  output logic [IDWidth-1:0]       rs_alu_vj_out,
  output logic [IDWidth-1:0]       rs_alu_vk_out,
  output logic [IDWidth-1:0]       rs_alu_a_out,
  output logic [AddressWidth-1:0]  rs_alu_pc_out,
  output logic [ROBWidth-1:0]      rs_alu_dest_out
);

  localparam int unsigned RSWidth  = $clog2(RS_SIZE);
  localparam int unsigned CntWidth = RSWidth + 1;

  rs_entry_t           entry_q [RS_SIZE];
  rs_entry_t           entry_d [RS_SIZE];
  issue_t              out_q;
  issue_t              out_d;
  logic                en_q;
  logic                en_d;
  logic [RS_SIZE-1:0]  free_vec;
  logic [RS_SIZE-1:0]  ready_vec;
  logic                free_found;
  logic                ready_found;
  logic [RSWidth-1:0]  free_idx;
  logic [RSWidth-1:0]  ready_idx;
  logic [CntWidth-1:0] free_cnt;
  cdb_t                cdb_alu;
  cdb_t                cdb_lsb;
  operand_t            new_j;
  operand_t            new_k;

  assign cdb_alu = '{en: cdb_alu_en_in, tag: cdb_alu_tag_in, value: cdb_alu_value_in};
`ifdef RS_DUAL_CDB_EN
  assign cdb_lsb = '{en: cdb_lsb_en_in, tag: cdb_lsb_tag_in, value: cdb_lsb_value_in};
`else
  assign cdb_lsb = '0;
`endif

  // Ready is judged on registered tags only, so a wakeup this cycle issues next cycle at the earliest.
  always_comb begin
    free_vec  = '0;
    ready_vec = '0;
    free_cnt  = '0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      free_vec[i]  = !entry_q[i].busy;
      ready_vec[i] = entry_q[i].busy && (entry_q[i].j.q == '0) && (entry_q[i].k.q == '0);
      free_cnt     = free_cnt + CntWidth'(free_vec[i]);
    end
  end

  // Keep two free slots so a dispatch already in flight always finds room.
  assign rs_full_out = (free_cnt < CntWidth'(2));

  rs_select #(.N(RS_SIZE)) u_free_sel (
    .req     (free_vec),
    .found_c (free_found),
    .idx_c   (free_idx)
  );

  rs_select #(.N(RS_SIZE)) u_ready_sel (
    .req     (ready_vec),
    .found_c (ready_found),
    .idx_c   (ready_idx)
  );

  always_comb begin
    entry_d = entry_q;
    out_d   = out_q;
    en_d    = 1'b0;
    new_j   = snoop(operand_t'{q: dispatcher_rs_qj_in, v: dispatcher_rs_vj_in}, cdb_alu, cdb_lsb);
    new_k   = snoop(operand_t'{q: dispatcher_rs_qk_in, v: dispatcher_rs_vk_in}, cdb_alu, cdb_lsb);
    if (rob_rs_clear_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        entry_d[i].busy = 1'b0;
      end
    end else begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        if (entry_q[i].busy) begin
          entry_d[i].j = snoop(entry_q[i].j, cdb_alu, cdb_lsb);
          entry_d[i].k = snoop(entry_q[i].k, cdb_alu, cdb_lsb);
        end
      end
      if (ready_found) begin
        out_d = '{opcode: entry_q[ready_idx].opcode,
                  vj:     entry_q[ready_idx].j.v,
                  vk:     entry_q[ready_idx].k.v,
                  a:      entry_q[ready_idx].a,
                  pc:     entry_q[ready_idx].pc,
                  dest:   entry_q[ready_idx].dest};
        en_d  = 1'b1;
        entry_d[ready_idx].busy = 1'b0;
      end
      // The free slot is never the issuing slot, so both updates can land on the same edge.
      if (dispatcher_rs_en_in && free_found) begin
        entry_d[free_idx] = '{busy:   1'b1,
                              opcode: dispatcher_rs_opcode_in,
                              j:      new_j,
                              k:      new_k,
                              a:      dispatcher_rs_a_in,
                              pc:     dispatcher_rs_pc_in,
                              dest:   dispatcher_rs_dest_in};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        entry_q[i] <= '0;
      end
      out_q <= '0;
      en_q  <= 1'b0;
    end else if (rdy_in) begin
      entry_q <= entry_d;
      out_q   <= out_d;
      en_q    <= en_d;
    end else begin
      en_q    <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && !rob_rs_clear_in && dispatcher_rs_en_in && !free_found) begin
      $error("reservation_station: dispatch dropped with no free entry");
    end
  end
`endif

  assign rs_alu_en_out     = en_q;
  assign rs_alu_opcode_out = out_q.opcode;
  assign rs_alu_vj_out     = out_q.vj;
  assign rs_alu_vk_out     = out_q.vk;
  assign rs_alu_a_out      = out_q.a;
  assign rs_alu_pc_out     = out_q.pc;
  assign rs_alu_dest_out   = out_q.dest;

endmodule

// File: tb/tb_reservation_station.sv
// Directed and randomized bench for reservation_station against a slot-array reference model.
module tb_reservation_station;
  import reservation_station_pkg::*;

  localparam int unsigned RS = 16;
`ifdef RS_DUAL_CDB_EN
  localparam bit Dual = 1'b1;
`else
  localparam bit Dual = 1'b0;
`endif

  logic                     clk_in = 1'b0;
  logic                     rst_in;
  logic                     rdy_in;
  logic                     rob_rs_clear_in;
  logic                     dispatcher_rs_en_in;
  logic [IDWidth-1:0]       dispatcher_rs_a_in;
  logic [ROBWidth-1:0]      dispatcher_rs_qj_in;
  logic [ROBWidth-1:0]      dispatcher_rs_qk_in;
  logic [IDWidth-1:0]       dispatcher_rs_vj_in;
  logic [IDWidth-1:0]       dispatcher_rs_vk_in;
  logic [ROBWidth-1:0]      dispatcher_rs_dest_in;
  logic [AddressWidth-1:0]  dispatcher_rs_pc_in;
  logic [InstTypeWidth-1:0] dispatcher_rs_opcode_in;
  logic                     cdb_alu_en_in;
  logic [ROBWidth-1:0]      cdb_alu_tag_in;
  logic [IDWidth-1:0]       cdb_alu_value_in;
  logic                     cdb_lsb_en_in;
  logic [ROBWidth-1:0]      cdb_lsb_tag_in;
  logic [IDWidth-1:0]       cdb_lsb_value_in;
  logic                     rs_full_out;
  logic                     rs_alu_en_out;
  logic [InstTypeWidth-1:0] rs_alu_opcode_out;
  logic [IDWidth-1:0]       rs_alu_vj_out;
  logic [IDWidth-1:0]       rs_alu_vk_out;
  logic [IDWidth-1:0]       rs_alu_a_out;
  logic [AddressWidth-1:0]  rs_alu_pc_out;
  logic [ROBWidth-1:0]      rs_alu_dest_out;

  always #5 clk_in = ~clk_in;

  reservation_station #(.RS_SIZE(RS)) dut (
    .clk_in                  (clk_in),
    .rst_in                  (rst_in),
    .rdy_in                  (rdy_in),
    .rob_rs_clear_in         (rob_rs_clear_in),
    .dispatcher_rs_en_in     (dispatcher_rs_en_in),
    .dispatcher_rs_a_in      (dispatcher_rs_a_in),
    .dispatcher_rs_qj_in     (dispatcher_rs_qj_in),
    .dispatcher_rs_qk_in     (dispatcher_rs_qk_in),
    .dispatcher_rs_vj_in     (dispatcher_rs_vj_in),
    .dispatcher_rs_vk_in     (dispatcher_rs_vk_in),
    .dispatcher_rs_dest_in   (dispatcher_rs_dest_in),
    .dispatcher_rs_pc_in     (dispatcher_rs_pc_in),
    .dispatcher_rs_opcode_in (dispatcher_rs_opcode_in),
    .cdb_alu_en_in           (cdb_alu_en_in),
    .cdb_alu_tag_in          (cdb_alu_tag_in),
    .cdb_alu_value_in        (cdb_alu_value_in),
`ifdef RS_DUAL_CDB_EN
    .cdb_lsb_en_in           (cdb_lsb_en_in),
    .cdb_lsb_tag_in          (cdb_lsb_tag_in),
    .cdb_lsb_value_in        (cdb_lsb_value_in),
`endif
    .rs_full_out             (rs_full_out),
    .rs_alu_en_out           (rs_alu_en_out),
    .rs_alu_opcode_out       (rs_alu_opcode_out),
    .rs_alu_vj_out           (rs_alu_vj_out),
    .rs_alu_vk_out           (rs_alu_vk_out),
    .rs_alu_a_out            (rs_alu_a_out),
    .rs_alu_pc_out           (rs_alu_pc_out),
    .rs_alu_dest_out         (rs_alu_dest_out)
  );

  // Reference model: an array of slots updated once per clock by the operational rules.
  typedef struct {
    bit                       busy;
    logic [InstTypeWidth-1:0] op;
    logic [ROBWidth-1:0]      qj;
    logic [ROBWidth-1:0]      qk;
    logic [IDWidth-1:0]       vj;
    logic [IDWidth-1:0]       vk;
    logic [IDWidth-1:0]       a;
    logic [AddressWidth-1:0]  pc;
    logic [ROBWidth-1:0]      dest;
  } m_ent_t;

  m_ent_t                   m [RS];
  logic                     e_en;
  logic [InstTypeWidth-1:0] e_op;
  logic [IDWidth-1:0]       e_vj;
  logic [IDWidth-1:0]       e_vk;
  logic [IDWidth-1:0]       e_a;
  logic [AddressWidth-1:0]  e_pc;
  logic [ROBWidth-1:0]      e_dest;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void resolve(input logic [ROBWidth-1:0] qi, input logic [IDWidth-1:0] vi,
                                  output logic [ROBWidth-1:0] qo, output logic [IDWidth-1:0] vo);
    qo = qi;
    vo = vi;
    if (qi != '0) begin
      if (cdb_alu_en_in && cdb_alu_tag_in == qi) begin
        qo = '0;
        vo = cdb_alu_value_in;
      end else if (Dual && cdb_lsb_en_in && cdb_lsb_tag_in == qi) begin
        qo = '0;
        vo = cdb_lsb_value_in;
      end
    end
  endfunction

  function automatic bit model_full();
    int nfree = 0;
    for (int i = 0; i < int'(RS); i++) if (!m[i].busy) nfree++;
    return nfree < 2;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < int'(RS); i++) m[i].busy = 1'b0;
    e_en = 1'b0; e_op = '0; e_vj = '0; e_vk = '0; e_a = '0; e_pc = '0; e_dest = '0;
  endfunction

  function automatic void model_step();
    int sel = -1;
    int fr  = -1;
    logic [ROBWidth-1:0] q;
    logic [IDWidth-1:0]  v;
    if (rst_in) begin
      model_reset();
      return;
    end
    if (!rdy_in) begin
      e_en = 1'b0;
      return;
    end
    if (rob_rs_clear_in) begin
      for (int i = 0; i < int'(RS); i++) m[i].busy = 1'b0;
      e_en = 1'b0;
      return;
    end
    for (int i = 0; i < int'(RS); i++) begin
      if (sel < 0 && m[i].busy && m[i].qj == '0 && m[i].qk == '0) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    for (int i = 0; i < int'(RS); i++) begin
      if (m[i].busy) begin
        resolve(m[i].qj, m[i].vj, q, v); m[i].qj = q; m[i].vj = v;
        resolve(m[i].qk, m[i].vk, q, v); m[i].qk = q; m[i].vk = v;
      end
    end
    if (sel >= 0) begin
      e_en = 1'b1; e_op = m[sel].op; e_vj = m[sel].vj; e_vk = m[sel].vk;
      e_a = m[sel].a; e_pc = m[sel].pc; e_dest = m[sel].dest;
      m[sel].busy = 1'b0;
    end else begin
      e_en = 1'b0;
    end
    if (dispatcher_rs_en_in && fr >= 0) begin
      m[fr].busy = 1'b1; m[fr].op = dispatcher_rs_opcode_in; m[fr].a = dispatcher_rs_a_in;
      m[fr].pc = dispatcher_rs_pc_in; m[fr].dest = dispatcher_rs_dest_in;
      resolve(dispatcher_rs_qj_in, dispatcher_rs_vj_in, q, v); m[fr].qj = q; m[fr].vj = v;
      resolve(dispatcher_rs_qk_in, dispatcher_rs_vk_in, q, v); m[fr].qk = q; m[fr].vk = v;
    end
  endfunction

  // One clock: check full before the edge, advance the model, check the registered outputs after.
  task automatic tick();
    check("full", 64'(rs_full_out), 64'(model_full()));
    model_step();
    @(posedge clk_in);
    #1;
    check("en", 64'(rs_alu_en_out), 64'(e_en));
    check("opcode", 64'(rs_alu_opcode_out), 64'(e_op));
    check("vj", 64'(rs_alu_vj_out), 64'(e_vj));
    check("vk", 64'(rs_alu_vk_out), 64'(e_vk));
    check("a", 64'(rs_alu_a_out), 64'(e_a));
    check("pc", 64'(rs_alu_pc_out), 64'(e_pc));
    check("dest", 64'(rs_alu_dest_out), 64'(e_dest));
  endtask

  task automatic idle();
    rst_in = 1'b0; rdy_in = 1'b1; rob_rs_clear_in = 1'b0;
    dispatcher_rs_en_in = 1'b0; dispatcher_rs_a_in = '0;
    dispatcher_rs_qj_in = '0; dispatcher_rs_qk_in = '0;
    dispatcher_rs_vj_in = '0; dispatcher_rs_vk_in = '0;
    dispatcher_rs_dest_in = '0; dispatcher_rs_pc_in = '0; dispatcher_rs_opcode_in = '0;
    cdb_alu_en_in = 1'b0; cdb_alu_tag_in = '0; cdb_alu_value_in = '0;
    cdb_lsb_en_in = 1'b0; cdb_lsb_tag_in = '0; cdb_lsb_value_in = '0;
  endtask

  task automatic disp(input logic [ROBWidth-1:0] qj, input logic [IDWidth-1:0] vj,
                      input logic [ROBWidth-1:0] qk, input logic [IDWidth-1:0] vk,
                      input logic [ROBWidth-1:0] dest);
    dispatcher_rs_en_in     = 1'b1;
    dispatcher_rs_qj_in     = qj;
    dispatcher_rs_vj_in     = vj;
    dispatcher_rs_qk_in     = qk;
    dispatcher_rs_vk_in     = vk;
    dispatcher_rs_dest_in   = dest;
    dispatcher_rs_a_in      = IDWidth'($urandom);
    dispatcher_rs_pc_in     = AddressWidth'($urandom);
    dispatcher_rs_opcode_in = InstTypeWidth'($urandom);
  endtask

  initial begin
    // Reset
    idle();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    model_reset();
    check("rst_en", 64'(rs_alu_en_out), 64'(0));
    check("rst_full", 64'(rs_full_out), 64'(0));
    check("rst_vj", 64'(rs_alu_vj_out), 64'(0));
    check("rst_dest", 64'(rs_alu_dest_out), 64'(0));
    idle();

    // Ready operands: issue two cycles after dispatch
    disp(4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
    tick(); idle();
    tick();
    check("t1_en", 64'(rs_alu_en_out), 64'(1));
    check("t1_vj", 64'(rs_alu_vj_out), 64'(5));
    check("t1_vk", 64'(rs_alu_vk_out), 64'(7));
    check("t1_dest", 64'(rs_alu_dest_out), 64'(3));
    tick();
    check("t1_pulse", 64'(rs_alu_en_out), 64'(0));

    // Waiting operand woken by ALU CDB
    disp(4'd4, 32'hdead, 4'd0, 32'd1, 4'd5);
    tick(); idle();
    repeat (3) tick();
    check("t2_wait", 64'(rs_alu_en_out), 64'(0));
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 4'd4; cdb_alu_value_in = 32'h10;
    tick(); idle();
    tick();
    check("t2_en", 64'(rs_alu_en_out), 64'(1));
    check("t2_vj", 64'(rs_alu_vj_out), 64'(32'h10));
    tick();

    // Same-cycle bypass at allocate
    disp(4'd0, 32'd2, 4'd6, 32'hbeef, 4'd7);
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 4'd6; cdb_alu_value_in = 32'd9;
    tick(); idle();
    tick();
    check("t3_en", 64'(rs_alu_en_out), 64'(1));
    check("t3_vk", 64'(rs_alu_vk_out), 64'(9));
    tick();

    // Fill RS_SIZE-1 entries blocked on tag 2, then release in index order
    for (int i = 0; i < int'(RS) - 1; i++) begin
      disp(4'd2, 32'(i), 4'd0, 32'(100 + i), ROBWidth'(i + 1));
      tick();
    end
    idle();
    check("t4_full", 64'(rs_full_out), 64'(1));
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 4'd2; cdb_alu_value_in = 32'h22;
    tick(); idle();
    tick();
    check("t4_first_en", 64'(rs_alu_en_out), 64'(1));
    check("t4_first_dest", 64'(rs_alu_dest_out), 64'(1));
    check("t4_full_drop", 64'(rs_full_out), 64'(0));
    repeat (RS) tick();

    // Clear with 8 busy entries during a CDB broadcast
    for (int i = 0; i < 8; i++) begin
      disp(4'd7, 32'(i), 4'd0, 32'(i), ROBWidth'(i));
      tick();
    end
    idle();
    rob_rs_clear_in = 1'b1;
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 4'd7; cdb_alu_value_in = 32'h77;
    tick(); idle();
    check("t5_en", 64'(rs_alu_en_out), 64'(0));
    check("t5_full", 64'(rs_full_out), 64'(0));
    repeat (3) tick();
    check("t5_no_issue", 64'(rs_alu_en_out), 64'(0));

    // rdy low holds state and suppresses the issue pulse
    disp(4'd0, 32'haa, 4'd0, 32'hbb, 4'd9);
    tick(); idle();
    rdy_in = 1'b0;
    repeat (3) tick();
    check("t6_hold_en", 64'(rs_alu_en_out), 64'(0));
    rdy_in = 1'b1;
    tick();
    check("t6_en", 64'(rs_alu_en_out), 64'(1));
    check("t6_vj", 64'(rs_alu_vj_out), 64'(32'haa));

`ifdef RS_DUAL_CDB_EN
    // Both buses carry the same tag: ALU value wins
    idle();
    disp(4'd5, 32'h0, 4'd0, 32'h3, 4'd2);
    tick(); idle();
    cdb_alu_en_in = 1'b1; cdb_alu_tag_in = 4'd5; cdb_alu_value_in = 32'd1;
    cdb_lsb_en_in = 1'b1; cdb_lsb_tag_in = 4'd5; cdb_lsb_value_in = 32'd2;
    tick(); idle();
    tick();
    check("t7_en", 64'(rs_alu_en_out), 64'(1));
    check("t7_vj", 64'(rs_alu_vj_out), 64'(1));
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy_in = ($urandom_range(9) != 0);
      rob_rs_clear_in = ($urandom_range(49) == 0);
      if (!rs_full_out && $urandom_range(1) == 1)
        disp(ROBWidth'($urandom_range(3)), IDWidth'($urandom), ROBWidth'($urandom_range(3)),
             IDWidth'($urandom), ROBWidth'($urandom));
      cdb_alu_en_in    = ($urandom_range(2) == 0);
      cdb_alu_tag_in   = ROBWidth'($urandom_range(3));
      cdb_alu_value_in = IDWidth'($urandom);
      cdb_lsb_en_in    = ($urandom_range(2) == 0);
      cdb_lsb_tag_in   = ROBWidth'($urandom_range(3));
      cdb_lsb_value_in = IDWidth'($urandom);
      tick();
    end
    idle();
    repeat (RS + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
